tile_result_drain: RTL and testbench
====================================

// Module: tile_result_drain
// PURPOSE
//   Downstream stage of the 4x4 systolic array. Captures the 16-lane tile result on tile_done.
//   Holds it in a two-slot ping-pong buffer so the array can start the next tile.
//   Streams each tile out row-major, one 4-lane row per valid/ready beat, tagged with tile id and row.
// PARAMETERS
//   ACC_WIDTH  16  width of one signed accumulator lane (matches the array)
//   TILE_ID_W  8   width of the output tile sequence counter
// PORTS
//   clk               in   1             clock
//   rst               in   1             synchronous, active-high reset
//   tile_done         in   1             1-cycle pulse from array: tile_result_flat is valid this cycle
//   tile_result_flat  in   ACC_WIDTH*16  lane r*4+c at [(r*4+c)*ACC_WIDTH +: ACC_WIDTH]
//   capture_ready     out  1             a free slot exists (count<2); controller gates tile_clear on it
//   out_valid         out  1             a row is presented
//   out_ready         in   1             downstream accepts the row
//   out_data          out  ACC_WIDTH*4   lane c at [c*ACC_WIDTH +: ACC_WIDTH], row out_row of current tile
//   out_row           out  2             row index 0..3
//   out_last          out  1             out_row==3
//   out_tile_id       out  TILE_ID_W     sequence number of the tile being drained
//   overflow_err      out  1             sticky: a tile_done was dropped
// BEHAVIOUR
//   - Reset: all outputs 0, count=0, wr_ptr=rd_ptr=0, row_idx=0, tile_id=0, slot contents don't-care.
//     capture_ready=1 one cycle after rst falls.
//   - Reset mid-drain: buffered tiles are discarded; out_valid=0 the cycle after rst is sampled.
//   - State: count (0..2), wr_ptr, rd_ptr, row_idx (0..3), tile_id.
//     out_valid = (count!=0); outputs mux from slot[rd_ptr] row row_idx; no combinational in->out path.
//   - Capture: on tile_done, accept if count<2 OR the final-row handshake occurs this cycle.
//     Accept writes slot[wr_ptr] and toggles wr_ptr. Otherwise drop the tile and set overflow_err (cleared only by rst).
//   - Latency: tile_done at cycle N into empty buffer -> out_valid=1, out_row=0 at N+1.
//   - Handshake: beat completes when out_valid & out_ready.
//     While out_valid & ~out_ready, out_data, out_row, out_last and out_tile_id hold stable.
//   - On a completed beat, row_idx++. On the completed beat with row_idx==3: row_idx<=0, rd_ptr toggles, count--,
//     tile_id++ (wraps mod 2^TILE_ID_W).
//   - Simultaneous capture + final beat: count unchanged, both pointers toggle.
//   - Full throughput: 4 beats per tile. out_valid stays 1 across tile boundaries when the second slot is full.
//   - Lanes are stored and emitted bit-exact (signed Q-format passes through); no width change.
// CONFIGURATION
//   DRAIN_RELU_EN defined: each lane is clamped at capture (negative -> 0, else unchanged); no latency change.
//   Not defined: lanes pass through unmodified, negatives included.
// STRUCTURE
//   Shared package systolic_pkg:
//     - ARRAY_DIM=4 and ACC_WIDTH localparams.
//     - typedef acc_t (signed [ACC_WIDTH-1:0]) and row_t (acc_t [ARRAY_DIM-1:0]).
//     - function relu_clamp(acc_t).
//   Single module, no sub-module: two row_t[4] slot arrays plus the counter/pointer logic above.
// TESTING
//   1 Reset, then tile_done with lanes = index 0..15, out_ready=1
//     -> rows {0,1,2,3},{4,5,6,7},...,{12..15} at N+1..N+4; out_last on beat 4; tile_id=0.
//   2 Two tile_done pulses 2 cycles apart (tiles A, B), out_ready=1
//     -> 8 contiguous beats A rows 0-3 then B rows 0-3, tile_id 0 then 1; capture_ready=0 only while both slots are held.
//   3 Third tile_done while count=2 and out_ready=0
//     -> tile dropped, overflow_err=1 and stays 1; drained data is still A then B.
//   4 count=2, tile_done coincident with final-row handshake of A
//     -> C accepted, no overflow; stream continues B rows 0-3 then C.
//   5 out_ready toggled 1,0,0,1 mid-tile -> out_data/out_row stable during stalls; no beat lost or repeated.
//   6 Lane = 16'h8001 (negative) -> emitted 16'h8001 by default, 16'h0000 with DRAIN_RELU_EN;
//     rst asserted mid-drain -> out_valid=0 next cycle, tile_id=0.

Source files
------------

// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
//   Types and helpers shared by the 4x4 systolic array and its downstream
//   stages.
//   ARRAY_DIM  : edge length of the array (tiles are ARRAY_DIM x ARRAY_DIM)
//   ACC_WIDTH  : width of one signed accumulator lane
//   acc_t      : one signed accumulator lane
//   row_t      : one row of ARRAY_DIM lanes, lane c at bits [c*ACC_WIDTH +: ACC_WIDTH]
//   relu_clamp : forces negative lanes to zero and passes the rest unchanged
// ---------------------------------------------------------------------------
package systolic_pkg;

  localparam int ARRAY_DIM = 4;
  localparam int ACC_WIDTH = 16;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef acc_t [ARRAY_DIM-1:0]        row_t;

  function automatic acc_t relu_clamp(input acc_t v);
    return v[ACC_WIDTH-1] ? acc_t'(0) : v;
  endfunction

endpackage

// File: rtl/tile_result_drain.sv
// ---------------------------------------------------------------------------
// tile_result_drain
//   Captures a 16-lane tile result from the systolic array on tile_done and
//   holds it in a two-slot ping-pong buffer. This frees the array to start
//   the next tile. Each buffered tile streams out row-major, one 4-lane row
//   per valid/ready beat, and each beat is tagged with a tile sequence number
//   and a row index.
//
// Configuration macro:
//   DRAIN_RELU_EN - when defined, negative lanes are clamped to zero at
//                   capture. This adds no latency.
//
// Ports:
//   clk              clock
//   rst              synchronous, active-high reset
//   tile_done        1-cycle pulse; tile_result_flat is valid this cycle
//   tile_result_flat lane r*4+c at [(r*4+c)*ACC_WIDTH +: ACC_WIDTH]
//   capture_ready    a free slot exists (registered, low during reset)
//   out_valid        a row is presented
//   out_ready        downstream accepts the row
//   out_data         lane c at [c*ACC_WIDTH +: ACC_WIDTH]
//   out_row          row index 0..3 of the presented row
//   out_last         presented row is the final row of its tile
//   out_tile_id      sequence number of the tile being drained
//   overflow_err     sticky: a tile_done was dropped (cleared only by rst)
//
// ACC_WIDTH must equal systolic_pkg::ACC_WIDTH. The lane storage uses the
// package types.
// ---------------------------------------------------------------------------
module tile_result_drain #(
  parameter int ACC_WIDTH = 16,
  parameter int TILE_ID_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tile_done,
  input  logic [ACC_WIDTH*16-1:0] tile_result_flat,
  output logic                   capture_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH*4-1:0] out_data,
  output logic [1:0]             out_row,
  output logic                   out_last,
  output logic [TILE_ID_W-1:0]   out_tile_id,
  output logic                   overflow_err
);

  import systolic_pkg::*;

  // Ping-pong storage: one row_t[4] array per slot.
  row_t slot0 [ARRAY_DIM];
  row_t slot1 [ARRAY_DIM];

  logic [1:0]           count;      // buffered tiles, 0..2
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           row_idx;
  logic [TILE_ID_W-1:0] tile_id;

  row_t                 cap_rows [ARRAY_DIM];
  row_t                 rd_row;
  logic                 beat;
  logic                 final_beat;
  logic                 accept;
  logic [1:0]           count_nxt;

  assign out_valid  = (count != 2'd0);
  assign beat       = out_valid & out_ready;
  assign final_beat = beat & (row_idx == 2'd3);
  // A full buffer can still take a tile when its oldest tile leaves this
  // cycle. The slot being written is the slot that finishes draining now.
  assign accept     = tile_done & ((count != 2'd2) | final_beat);

  // Unpack the flat array result into rows, applying the optional clamp.
  always_comb begin
    // NOTE: a default for every always_comb output comes first, so no path
    // can leave a bit unassigned and infer a latch.
    for (int r = 0; r < ARRAY_DIM; r++) cap_rows[r] = '0;
    for (int r = 0; r < ARRAY_DIM; r++) begin
      for (int c = 0; c < ARRAY_DIM; c++) begin
`ifdef DRAIN_RELU_EN
        cap_rows[r][c] = relu_clamp(tile_result_flat[(r*ARRAY_DIM+c)*ACC_WIDTH +: ACC_WIDTH]);
`else
        cap_rows[r][c] = tile_result_flat[(r*ARRAY_DIM+c)*ACC_WIDTH +: ACC_WIDTH];
`endif
      end
    end
  end

  always_comb begin
    count_nxt = count;
    case ({accept, final_beat})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;  // idle, or capture and final beat together
    endcase
  end

  // NOTE: slot contents have no reset. They are only read while out_valid
  // is high, and out_valid cannot rise until a capture has written the slot.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_ptr) slot1 <= cap_rows;
      else        slot0 <= cap_rows;
    end
  end

  // NOTE: every register update uses non-blocking assignment. Then all state
  // moves together on the edge, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      row_idx       <= 2'd0;
      tile_id       <= '0;
      overflow_err  <= 1'b0;
      capture_ready <= 1'b0;
    end else begin
      count         <= count_nxt;
      capture_ready <= (count_nxt != 2'd2);
      if (accept) wr_ptr <= ~wr_ptr;
      if (tile_done && !accept) overflow_err <= 1'b1;
      if (beat) begin
        row_idx <= row_idx + 2'd1;  // 3 wraps to 0 on the final beat
        if (final_beat) begin
          rd_ptr  <= ~rd_ptr;
          tile_id <= tile_id + TILE_ID_W'(1);
        end
      end
    end
  end

  // Outputs come only from registers. Data is forced to zero while nothing
  // is presented, so the reset-time outputs read as zero.
  assign rd_row      = rd_ptr ? slot1[row_idx] : slot0[row_idx];
  assign out_data    = out_valid ? rd_row : '0;
  assign out_row     = row_idx;
  assign out_last    = (row_idx == 2'd3);
  assign out_tile_id = tile_id;

endmodule

// File: tb/tb_tile_result_drain.sv
// ---------------------------------------------------------------------------
// tb_tile_result_drain
//   Self-checking bench for tile_result_drain. A reference model holds a
//   queue of buffered tiles, the current row, the tile counter and the
//   sticky overflow flag. Outputs are compared on every falling edge.
//   Compile with DRAIN_RELU_EN defined to check the clamping build.
// ---------------------------------------------------------------------------
module tb_tile_result_drain;

  typedef logic [255:0] tile_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         tile_done;
  tile_t        tile_result_flat;
  logic         capture_ready;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [1:0]   out_row;
  logic         out_last;
  logic [7:0]   out_tile_id;
  logic         overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  tile_t      m_q[$];
  int         m_row;
  logic [7:0] m_id;
  logic       m_ovf;

  tile_result_drain #(.ACC_WIDTH(16), .TILE_ID_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .tile_done        (tile_done),
    .tile_result_flat (tile_result_flat),
    .capture_ready    (capture_ready),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_row          (out_row),
    .out_last         (out_last),
    .out_tile_id      (out_tile_id),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic tile_t model_capture(input tile_t t);
    tile_t r;
    r = t;
`ifdef DRAIN_RELU_EN
    for (int i = 0; i < 16; i++) if (t[i*16+15]) r[i*16 +: 16] = 16'h0000;
`endif
    return r;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  function automatic tile_t index_tile();
    tile_t t;
    for (int i = 0; i < 16; i++) t[i*16 +: 16] = 16'(i);
    return t;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_row = 0;
    m_id  = '0;
    m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    check("valid",     {63'd0, out_valid},     {63'd0, m_q.size() != 0});
    check("cap_ready", {63'd0, capture_ready}, {63'd0, m_q.size() < 2});
    check("overflow",  {63'd0, overflow_err},  {63'd0, m_ovf});
    check("row",       {62'd0, out_row},       64'(m_row));
    check("last",      {63'd0, out_last},      {63'd0, m_row == 3});
    check("tile_id",   {56'd0, out_tile_id},   {56'd0, m_id});
    if (m_q.size() != 0) check("data", out_data, m_q[0][m_row*64 +: 64]);
  endtask

  // One clock cycle. Check the presented state, drive inputs, advance the
  // model by the same handshake rules, then move to the next falling edge.
  task automatic tick(input bit td, input tile_t t, input bit rdy);
    bit valid;
    bit final_beat;
    bit accept;
    check_outputs();
    tile_done        = td;
    tile_result_flat = t;
    out_ready        = rdy;
    valid      = (m_q.size() != 0);
    final_beat = valid && rdy && (m_row == 3);
    accept     = td && ((m_q.size() < 2) || final_beat);
    if (valid && rdy) begin
      if (m_row == 3) begin
        void'(m_q.pop_front());
        m_row = 0;
        m_id  = m_id + 8'd1;
      end else begin
        m_row = m_row + 1;
      end
    end
    if (accept)  m_q.push_back(model_capture(t));
    else if (td) m_ovf = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, '0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1; tile_done = 1'b0; out_ready = 1'b0; tile_result_flat = '0;
    repeat (2) @(negedge clk);
    check("rst_valid",    {63'd0, out_valid},     64'd0);
    check("rst_cap",      {63'd0, capture_ready}, 64'd0);
    check("rst_data",     out_data,               64'd0);
    check("rst_row",      {62'd0, out_row},       64'd0);
    check("rst_last",     {63'd0, out_last},      64'd0);
    check("rst_tile_id",  {56'd0, out_tile_id},   64'd0);
    check("rst_overflow", {63'd0, overflow_err},  64'd0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  initial begin
    tile_t a, b, c, t6;
    logic [15:0] neg_exp;
    rst = 1'b1; tile_done = 1'b0; out_ready = 1'b0; tile_result_flat = '0;
    model_clear();

    // 1: single tile with lanes 0..15, drained at full rate.
    do_reset();
    tick(1'b1, index_tile(), 1'b1);
    check("t1_row0", out_data, 64'h0003_0002_0001_0000);
    idle(6, 1'b1);

    // 2: two tiles two cycles apart, back-to-back stream.
    do_reset();
    a = rand_tile(); b = rand_tile();
    tick(1'b1, a, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b1, b, 1'b1);
    idle(9, 1'b1);

    // 3: third tile while both slots are held and downstream stalls.
    do_reset();
    a = rand_tile(); b = rand_tile(); c = rand_tile();
    tick(1'b1, a, 1'b0);
    tick(1'b1, b, 1'b0);
    tick(1'b1, c, 1'b0);
    idle(2, 1'b0);
    idle(10, 1'b1);
    check("t3_sticky", {63'd0, overflow_err}, 64'd1);

    // 4: tile arrives on the final-row handshake of a full buffer.
    do_reset();
    a = rand_tile(); b = rand_tile(); c = rand_tile();
    tick(1'b1, a, 1'b0);
    tick(1'b1, b, 1'b0);
    idle(3, 1'b1);
    tick(1'b1, c, 1'b1);
    idle(10, 1'b1);
    check("t4_no_ovf", {63'd0, overflow_err}, 64'd0);

    // 5: stalls in the middle of a tile.
    do_reset();
    tick(1'b1, rand_tile(), 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b1);
    idle(4, 1'b1);

    // 6: negative lane pass-through or clamp, then reset during a drain.
    do_reset();
    t6 = rand_tile();
    t6[15:0] = 16'h8001;
`ifdef DRAIN_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'h8001;
`endif
    tick(1'b1, t6, 1'b1);
    check("t6_neg_lane", {48'd0, out_data[15:0]}, {48'd0, neg_exp});
    tick(1'b1, rand_tile(), 1'b1);
    idle(5, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid",   {63'd0, out_valid},   64'd0);
    check("t6_rst_tile_id", {56'd0, out_tile_id}, 64'd0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    idle(2, 1'b1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++)
      tick(($urandom_range(0, 3) == 0), rand_tile(), ($urandom_range(0, 3) != 0));
    idle(12, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
